// File: rtl/jtag_sp_pkg.sv
// Shared definitions for the multi-channel JTAG source/probe array:
// instruction codes, INFO field layout and constant helper functions.
package jtag_sp_pkg;

  localparam int IR_W = 3;

  localparam logic [IR_W-1:0] IR_BYPASS = 3'b000;
  localparam logic [IR_W-1:0] IR_ADDR   = 3'b001;
  localparam logic [IR_W-1:0] IR_SOURCE = 3'b010;
  localparam logic [IR_W-1:0] IR_PROBE  = 3'b011;
  localparam logic [IR_W-1:0] IR_INFO   = 3'b100;

  // INFO word: channel count minus one above word width minus one
  localparam int INFO_DW_LSB  = 0;
  localparam int INFO_NCH_LSB = 8;
  localparam int INFO_FIELD_W = 8;
  localparam int INFO_W       = 16;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/jtag_sp_sync2.sv
// Two-flop synchronizer bringing W asynchronous probe bits into the tck domain.
module jtag_sp_sync2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/jtag_source_probe_array.sv
// NUM_CH source registers and probe inputs behind one virtual-JTAG node.
// Define JTAG_SP_PROBE_SYNC_EN to pass every probe bit through a 2-flop synchronizer.
module jtag_source_probe_array
  import jtag_sp_pkg::*;
#(
  parameter int              NUM_CH      = 4,
  parameter int              Dw          = 8,
  parameter logic [Dw-1:0]   SOURCE_INIT = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [IR_W-1:0]        ir_in,
  output logic [IR_W-1:0]        ir_out,
  input  logic                   tdi,
  output logic                   tdo,
  input  logic                   cdr,
  input  logic                   sdr,
  input  logic                   udr,
  input  logic                   uir,
  input  logic [NUM_CH*Dw-1:0]   probe,
  output logic [NUM_CH*Dw-1:0]   source
);

  localparam int AW = max_int(1, clog2(NUM_CH));
  localparam int SW = max_int(max_int(Dw, AW + 1), INFO_W);

  logic [IR_W-1:0]      ir;
  logic [AW-1:0]        ch_sel;
  logic                 autoinc;
  logic [SW-1:0]        shift_buf;
  logic                 bypass_reg;
  logic [Dw-1:0]        src_mem [NUM_CH];
  logic [NUM_CH*Dw-1:0] probe_cap;

  logic                 ir_dr;
  logic                 ir_is_source;
  logic                 ir_is_probe;
  logic                 ch_hit;
  logic [Dw-1:0]        src_sel;
  logic [Dw-1:0]        probe_sel;
  logic [AW-1:0]        ch_next;
  logic [SW-1:0]        capture_val;

`ifdef JTAG_SP_PROBE_SYNC_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_probe_sync
    jtag_sp_sync2 #(
      .W (Dw)
    ) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (probe[k*Dw +: Dw]),
      .q     (probe_cap[k*Dw +: Dw])
    );
  end
`else
  assign probe_cap = probe;
`endif

  assign ir_out       = ir_in;
  assign ir_is_source = (ir == IR_SOURCE);
  assign ir_is_probe  = (ir == IR_PROBE);
  assign ir_dr        = (ir == IR_ADDR) || ir_is_source || ir_is_probe || (ir == IR_INFO);
  assign tdo          = ir_dr ? shift_buf[0] : bypass_reg;

  // Channel decode; ch_hit stays low when ch_sel points past the last channel
  always_comb begin
    ch_hit    = 1'b0;
    src_sel   = '0;
    probe_sel = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_sel == AW'(k)) begin
        ch_hit    = 1'b1;
        src_sel   = src_mem[k];
        probe_sel = probe_cap[k*Dw +: Dw];
      end
    end
  end

  always_comb begin
    if (!ch_hit || (ch_sel == AW'(NUM_CH - 1))) begin
      ch_next = '0;
    end else begin
      ch_next = ch_sel + AW'(1);
    end
  end

  always_comb begin
    capture_val = '0;
    case (ir)
      IR_ADDR: begin
        capture_val[AW-1:0] = ch_sel;
        capture_val[AW]     = autoinc;
      end
      IR_SOURCE: begin
        if (ch_hit) begin
          capture_val[Dw-1:0] = src_sel;
        end
      end
      IR_PROBE: begin
        if (ch_hit) begin
          capture_val[Dw-1:0] = probe_sel;
        end
      end
      IR_INFO: begin
        capture_val[INFO_NCH_LSB +: INFO_FIELD_W] = INFO_FIELD_W'(NUM_CH - 1);
        capture_val[INFO_DW_LSB  +: INFO_FIELD_W] = INFO_FIELD_W'(Dw - 1);
      end
      default: ;
    endcase
  end

  // Update sees the ir held before any coincident uir, since both are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ir         <= IR_BYPASS;
      ch_sel     <= '0;
      autoinc    <= 1'b0;
      shift_buf  <= '0;
      bypass_reg <= 1'b0;
    end else begin
      bypass_reg <= tdi;
      if (uir) begin
        ir <= ir_in;
      end
      if (ir_dr) begin
        if (cdr) begin
          shift_buf <= capture_val;
        end else if (sdr) begin
          shift_buf <= {tdi, shift_buf[SW-1:1]};
        end
      end
      if (udr) begin
        if (ir == IR_ADDR) begin
          ch_sel  <= shift_buf[AW-1:0];
          autoinc <= shift_buf[AW];
        end else if (autoinc && (ir_is_source || ir_is_probe)) begin
          ch_sel <= ch_next;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_CH; k++) begin
        src_mem[k] <= SOURCE_INIT;
      end
    end else if (udr && ir_is_source) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_sel == AW'(k)) begin
          src_mem[k] <= shift_buf[Dw-1:0];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_source_pack
    assign source[k*Dw +: Dw] = src_mem[k];
  end

endmodule

// File: tb/tb_jtag_source_probe_array.sv
// Scoreboard bench for jtag_source_probe_array: a three-channel instance so that
// an address past the last channel exists; expectations come from a behavioural model.
module tb_jtag_source_probe_array;

  localparam int              NUM_CH = 3;
  localparam int              DW     = 8;
  localparam int              AW     = 2;
  localparam int              SW     = 16;
  localparam int              CHW    = NUM_CH * DW;
  localparam logic [DW-1:0]   INIT   = 8'h5A;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic [2:0]     ir_in = 3'b000;
  logic [2:0]     ir_out;
  logic           tdi   = 1'b0;
  logic           tdo;
  logic           cdr   = 1'b0;
  logic           sdr   = 1'b0;
  logic           udr   = 1'b0;
  logic           uir   = 1'b0;
  logic [CHW-1:0] probe = '0;
  logic [CHW-1:0] source;

  int checks = 0;
  int errors = 0;

  logic [SW-1:0]  exp_cap_q [$];
  logic [CHW-1:0] exp_src_q [$];

  logic [DW-1:0]  m_src [NUM_CH];
  int             m_ch;
  bit             m_autoinc;
  logic [CHW-1:0] probe_seen = '0;

  logic [SW-1:0]  mon_bits;
  int             mon_nbits = 0;
  bit             mon_pending = 1'b0;

  jtag_source_probe_array #(
    .NUM_CH      (NUM_CH),
    .Dw          (DW),
    .SOURCE_INIT (INIT)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .ir_in  (ir_in),
    .ir_out (ir_out),
    .tdi    (tdi),
    .tdo    (tdo),
    .cdr    (cdr),
    .sdr    (sdr),
    .udr    (udr),
    .uir    (uir),
    .probe  (probe),
    .source (source)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < NUM_CH; k++) m_src[k] = INIT;
    m_ch      = 0;
    m_autoinc = 1'b0;
  endfunction

  function automatic logic [CHW-1:0] model_sources();
    logic [CHW-1:0] v;
    for (int k = 0; k < NUM_CH; k++) v[k*DW +: DW] = m_src[k];
    return v;
  endfunction

  // What the host reads back: register contents for data instructions, or the
  // shifted-in stream delayed by one bit for bypass.
  function automatic logic [SW-1:0] model_capture(input logic [2:0] code, input logic [SW-1:0] data);
    int v;
    v = 0;
    case (code)
      3'd1: v = (m_autoinc ? (1 << AW) : 0) + m_ch;
      3'd2: v = (m_ch < NUM_CH) ? int'(m_src[m_ch]) : 0;
      3'd3: v = (m_ch < NUM_CH) ? int'(probe_seen[m_ch*DW +: DW]) : 0;
      3'd4: v = ((NUM_CH - 1) << 8) + (DW - 1);
      default: return {data[SW-2:0], 1'b0};
    endcase
    return SW'(v);
  endfunction

  function automatic void model_update(input logic [2:0] code, input logic [SW-1:0] data);
    if (code == 3'd1) begin
      m_ch      = int'(data[AW-1:0]);
      m_autoinc = data[AW];
    end else if (code == 3'd2 && m_ch < NUM_CH) begin
      m_src[m_ch] = data[DW-1:0];
    end
    if (m_autoinc && (code == 3'd2 || code == 3'd3)) begin
      m_ch = (m_ch + 1 >= NUM_CH) ? 0 : m_ch + 1;
    end
  endfunction

  // One IR scan followed by one full DR scan; optionally changes probe in the IR cycle
  task automatic applyStimulus(input logic [2:0] code, input logic [SW-1:0] data,
                               input bit late, input logic [CHW-1:0] late_probe);
    logic [SW-1:0] exp_word;
    @(posedge clk); #1;
    ir_in = code;
    uir   = 1'b1;
    if (late) probe = late_probe;
    @(posedge clk); #1;
    uir = 1'b0;
    cdr = 1'b1;
    tdi = 1'b0;
`ifndef JTAG_SP_PROBE_SYNC_EN
    if (late) probe_seen = late_probe;
`endif
    exp_word = model_capture(code, data);
    if (late) probe_seen = late_probe;
    for (int i = 0; i < SW; i++) begin
      @(posedge clk); #1;
      cdr = 1'b0;
      sdr = 1'b1;
      tdi = data[i];
    end
    @(posedge clk); #1;
    sdr = 1'b0;
    tdi = 1'b0;
    udr = 1'b1;
    exp_cap_q.push_back(exp_word);
    model_update(code, data);
    exp_src_q.push_back(model_sources());
    @(posedge clk); #1;
    udr = 1'b0;
    @(posedge clk);
  endtask

  task automatic set_probe(input logic [CHW-1:0] v);
    @(posedge clk); #1;
    probe = v;
    repeat (3) @(posedge clk);
    probe_seen = v;
  endtask

  // Monitor: assembles tdo during shifts, checks it at each update strobe,
  // then checks the source bus one cycle after the update edge.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_nbits   = 0;
        mon_pending = 1'b0;
      end else begin
        if (mon_pending) begin
          mon_pending = 1'b0;
          if (exp_src_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL source_after_udr: no expected entry queued");
          end else begin
            checkOutput("source_after_udr", source, exp_src_q.pop_front());
          end
        end
        if (sdr) begin
          if (mon_nbits < SW) mon_bits[mon_nbits] = tdo;
          mon_nbits++;
        end
        if (udr) begin
          if (exp_cap_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL capture: no expected entry queued");
          end else begin
            checkOutput("capture", mon_bits, exp_cap_q.pop_front());
          end
          mon_nbits   = 0;
          mon_pending = 1'b1;
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset_source", source, {NUM_CH{INIT}});
    checkOutput("reset_tdo", tdo, 1'b0);
    ir_in = 3'b110;
    #1;
    checkOutput("ir_passthrough", ir_out, 3'b110);
    @(posedge clk); #1;
    reset = 1'b0;
    ir_in = 3'b000;

    applyStimulus(3'd4, 16'h1234, 1'b0, '0);
    applyStimulus(3'd1, 16'h0002, 1'b0, '0);
    applyStimulus(3'd2, 16'h00C3, 1'b0, '0);
    applyStimulus(3'd2, 16'h00C3, 1'b0, '0);
    applyStimulus(3'd1, 16'h0006, 1'b0, '0);
    applyStimulus(3'd2, 16'h0011, 1'b0, '0);
    applyStimulus(3'd2, 16'h0022, 1'b0, '0);
    applyStimulus(3'd1, 16'h0000, 1'b0, '0);

    set_probe(24'hCCBBAA);
    applyStimulus(3'd1, 16'h0004, 1'b0, '0);
    for (int i = 0; i < 4; i++) applyStimulus(3'd3, 16'($urandom), 1'b0, '0);

    applyStimulus(3'd1, 16'h0003, 1'b0, '0);
    applyStimulus(3'd2, 16'h00FF, 1'b0, '0);
    applyStimulus(3'd3, 16'h0000, 1'b0, '0);
    applyStimulus(3'd1, 16'h0007, 1'b0, '0);
    applyStimulus(3'd2, 16'h0044, 1'b0, '0);
    applyStimulus(3'd2, 16'h0022, 1'b0, '0);

    applyStimulus(3'd0, 16'hB00B, 1'b0, '0);
    applyStimulus(3'd6, 16'h000B, 1'b0, '0);

    applyStimulus(3'd1, 16'h0004, 1'b0, '0);
    applyStimulus(3'd3, 16'h0000, 1'b1, 24'h112233);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 5) == 0) set_probe(CHW'($urandom));
      applyStimulus(3'($urandom_range(0, 7)), 16'($urandom), 1'b0, '0);
    end

    applyStimulus(3'd1, 16'h0000, 1'b0, '0);
    applyStimulus(3'd2, 16'h0001, 1'b0, '0);

    @(posedge clk); #1;
    ir_in = 3'd2;
    uir   = 1'b1;
    @(posedge clk); #1;
    uir = 1'b0;
    cdr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      cdr = 1'b0;
      sdr = 1'b1;
      tdi = 1'($urandom);
    end
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_reset_source", source, {NUM_CH{INIT}});
    checkOutput("async_reset_tdo", tdo, 1'b0);
    sdr = 1'b0;
    tdi = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    applyStimulus(3'd1, 16'h0000, 1'b0, '0);
    applyStimulus(3'd2, 16'h005A, 1'b0, '0);
    applyStimulus(3'd4, 16'h0000, 1'b0, '0);

    repeat (3) @(posedge clk);
    checkOutput("queues_drained", exp_cap_q.size() + exp_src_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_source_probe_array.md
Name: jtag_source_probe_array

Overview:
Multi-channel successor of the single-word JTAG source/probe. It provides NUM_CH independent source registers and NUM_CH probe inputs of Dw bits each. All of them are reached through one virtual-JTAG node, using a channel-address register with an optional auto-increment. It sits beside the vjtag instance, with its clock driven by tck, and the host C tools in src_c/jtag drive it.

Parameters:
NUM_CH, 4, number of source/probe channels (1..256)
Dw, 8, width in bits of each source/probe word (1..64)
SOURCE_INIT, 0, reset value loaded into every source word (Dw bits)
AW, derived = max(1, clog2(NUM_CH)), channel address width (localparam)
SW, derived = max(Dw, AW+1, 16), data-register (shift buffer) length (localparam)

Ports:
clk  input  1  JTAG tck from the vjtag instance; all state is on its rising edge
reset  input  1  asynchronous, active-high reset
ir_in  input  3  virtual IR value from vjtag
ir_out  output  3  equals ir_in (combinational pass-through)
tdi  input  1  serial data in
tdo  output  1  serial data out
cdr  input  1  virtual_state_cdr
sdr  input  1  virtual_state_sdr
udr  input  1  virtual_state_udr
uir  input  1  virtual_state_uir
probe  input  NUM_CH*Dw  probe words; channel k occupies bits [k*Dw +: Dw]
source  output  NUM_CH*Dw  source words; same packing as probe

Behaviour:
- Single clock clk; reset is asynchronous and active-high.
- Reset state:
  - every source word = SOURCE_INIT
  - ir = BYPASS, ch_sel = 0, autoinc = 0
  - shift buffer = 0, bypass_reg = 0
- IR latch: ir <= ir_in on a clk edge with uir=1.
- Instruction codes:
  - 000 BYPASS
  - 001 ADDR
  - 010 SOURCE
  - 011 PROBE
  - 100 INFO
  - 101..111 behave as BYPASS
- BYPASS: bypass_reg <= tdi every edge; tdo = bypass_reg.
- All other instructions: tdo = shift_buf[0]. DR length is SW bits. On sdr: shift_buf <= {tdi, shift_buf[SW-1:1]} (LSB first out, MSB first in). Host always shifts exactly SW bits.
- Capture on cdr (zero-extended to SW):
  - ADDR: {autoinc, ch_sel}
  - SOURCE: source[ch_sel]
  - PROBE: probe[ch_sel]
  - INFO: {NUM_CH-1 in bits[15:8], Dw-1 in bits[7:0]}
  - If ch_sel >= NUM_CH, SOURCE and PROBE capture 0.
- Update on udr:
  - ADDR: ch_sel <= shift_buf[AW-1:0], autoinc <= shift_buf[AW].
  - SOURCE: source[ch_sel] <= shift_buf[Dw-1:0]. The write is dropped if ch_sel >= NUM_CH.
  - PROBE: no register write.
  - INFO: no register write.
- Auto-increment: if autoinc=1 and ir is SOURCE or PROBE, udr also advances ch_sel by 1. It wraps from NUM_CH-1 to 0; an out-of-range ch_sel also wraps to 0.
- Latency: a source word changes on the clk edge where udr=1. Captured data appears on tdo in the cycle after cdr.
- Priority when strobes are asserted together (illegal from a TAP, but defined): cdr > sdr. udr is evaluated independently. An uir in the same cycle as udr applies the update under the old ir.
- Reset asserted mid-shift aborts the scan. Sources return to SOURCE_INIT immediately (asynchronously).

Optional Feature:
JTAG_SP_PROBE_SYNC_EN
- Defined: each probe bit passes through a 2-flop synchronizer clocked by clk (reset to 0) before capture. A probe change becomes capturable 2 clk edges later.
- Undefined: probe is sampled directly at cdr, with no added flops.

Decomposition:
- Package jtag_sp_pkg holds:
  - instruction code localparams (BYPASS/ADDR/SOURCE/PROBE/INFO)
  - the IR width (3)
  - the INFO field positions
  - a clog2 function
- One sub-module, jtag_sp_sync2 (Dw-wide 2-flop synchronizer), is instantiated per channel only under JTAG_SP_PROBE_SYNC_EN.
- The vjtag instance stays outside the block, in the wrapper.

Test Plan:
- Reset: assert reset with SOURCE_INIT=8'h5A, NUM_CH=4 -> all four source words = 5A; INFO scan returns 16'h0307; ADDR scan returns 0.
- Addressed write: ADDR=2 (autoinc=0), SOURCE DR=8'hC3 -> source[2]=C3, others unchanged; a SOURCE capture returns C3 and leaves ch_sel=2.
- Auto-increment: ADDR={1,3}, then SOURCE writes 11,22 -> source[3]=11, source[0]=22 (wrap); ADDR capture returns {1,1}.
- Probe read: probe words = {AA,BB,CC,DD} (ch3..ch0), ADDR={1,0}, four PROBE scans -> DD, CC, BB, AA in order. With JTAG_SP_PROBE_SYNC_EN, a probe change made 1 clk before cdr reads the old value.
- Out of range: NUM_CH=3, ADDR=3, SOURCE write FF -> no source changes; PROBE capture = 0.
- Bypass: IR=000 or 110, shift pattern 1011 -> tdo returns the pattern delayed by one clk; async reset mid-scan -> sources restored immediately.
